// File: rtl/dice_roll_sequencer.sv
// dice_roll_sequencer
//   Runs one dice-core roll for each button press. A roll is a train of single-cycle
//   Step strobes whose spacing grows with every strobe, so the die appears to slow down.
//   The settled face is then latched as the roll result. Each face the core reports
//   after a Step is checked. An illegal face enters a sticky error state, and only
//   reset leaves that state.
//
// Ports
//   Clock      in   system clock, rising edge
//   nReset     in   asynchronous active-low reset
//   Roll       in   asynchronous button level; a rising edge requests a roll
//   DiceValue  in   [2:0] current face from the dice core, legal 1..6
//   Step       out  one-cycle strobe; the core advances on the edge that ends the cycle
//   Busy       out  high while a roll is in progress
//   Valid      out  Result holds a completed roll
//   Result     out  [2:0] latched final face
//   Error      out  sticky illegal-face flag
//   RollCount  out  [7:0] completed rolls, wraps 255 -> 0
module dice_roll_sequencer #(
    parameter int unsigned N_STEPS  = 12,
    parameter int unsigned INIT_GAP = 4,
    parameter int unsigned GAP_INC  = 2,
    parameter int unsigned GAP_W    = 8
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       Roll,
    input  logic [2:0] DiceValue,
    output logic       Step,
    output logic       Busy,
    output logic       Valid,
    output logic [2:0] Result,
    output logic       Error,
    output logic [7:0] RollCount
);

    localparam int unsigned STEP_W = $clog2(N_STEPS + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_TUMBLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_SHOW   = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam logic [GAP_W:0] GAP_MAX = {1'b0, {GAP_W{1'b1}}};

    logic [2:0]        sync_q;
    logic [2:0]        state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [2:0]        prev_q, prev_d;
    logic              step_q, step_d;
    logic              valid_q, valid_d;
    logic [2:0]        result_q, result_d;
    logic [7:0]        count_q, count_d;

    logic              roll_req;
    logic [GAP_W:0]    gap_sum;
    logic [GAP_W-1:0]  gap_next;
    logic [GAP_W:0]    cnt_inc;
    logic              gap_hit;
    logic              face_legal;
    logic              last_step;

    // Two flops resolve metastability and a third holds the previous level for edge detection.
    assign roll_req = sync_q[1] & ~sync_q[2];

    assign gap_sum  = {1'b0, gap_q} + (GAP_W + 1)'(GAP_INC);
    assign gap_next = (gap_sum > GAP_MAX) ? GAP_MAX[GAP_W-1:0] : gap_sum[GAP_W-1:0];

    // cnt_q counts cycles since the last Step (or since entry). Step is registered,
    // so it is requested one cycle before the gap elapses.
    assign cnt_inc  = {1'b0, cnt_q} + (GAP_W + 1)'(1);
    assign gap_hit  = (cnt_inc == {1'b0, gap_q});

    assign face_legal = (DiceValue != 3'd0) && (DiceValue != 3'd7) &&
                        (DiceValue != prev_q) && (DiceValue != (3'd7 - prev_q));
    assign last_step  = (steps_q == STEP_W'(N_STEPS));

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        steps_d  = steps_q;
        prev_d   = prev_q;
        step_d   = 1'b0;
        valid_d  = valid_q;
        result_d = result_q;
        count_d  = count_q;

        case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (roll_req) begin
                    state_d = ST_TUMBLE;
                    gap_d   = GAP_W'(INIT_GAP);
                    cnt_d   = '0;
                    steps_d = '0;
                    prev_d  = DiceValue;
                    valid_d = 1'b0;
                end
            end
            ST_TUMBLE: begin
                if (step_q) begin
                    state_d = ST_CHECK;
                    prev_d  = DiceValue;
                    steps_d = steps_q + STEP_W'(1);
                    gap_d   = gap_next;
                end else begin
                    step_d = gap_hit;
                end
                cnt_d = step_d ? '0 : cnt_inc[GAP_W-1:0];
            end
            ST_CHECK: begin
                if (!face_legal) begin
                    state_d = ST_ERROR;
                end else if (last_step) begin
                    state_d  = ST_SHOW;
                    result_d = DiceValue;
                    valid_d  = 1'b1;
                    count_d  = count_q + 8'd1;
                end else begin
                    // The CHECK cycle is part of the gap, so the timing carries on.
                    state_d = ST_TUMBLE;
                    step_d  = gap_hit;
                    cnt_d   = step_d ? '0 : cnt_inc[GAP_W-1:0];
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_q   <= '0;
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            cnt_q    <= '0;
            steps_q  <= '0;
            prev_q   <= '0;
            step_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= 3'd1;
            count_q  <= '0;
        end else begin
            sync_q   <= {sync_q[1:0], Roll};
            state_q  <= state_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            steps_q  <= steps_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    assign Step      = step_q;
    assign Busy      = (state_q == ST_TUMBLE) || (state_q == ST_CHECK);
    assign Valid     = valid_q;
    assign Result    = result_q;
    assign Error     = (state_q == ST_ERROR);
    assign RollCount = count_q;

endmodule
